// File: rtl/snn_aer_pkg.sv
// Shared AER link definitions: arbiter FSM states, owner encoding and default sizes.
package snn_aer_pkg;

  localparam int unsigned AER_ADDR_W      = 10;
  localparam int unsigned AER_ACK_TIMEOUT = 64;
  localparam int unsigned AER_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } aer_arb_state_t;

  typedef enum logic {
    OWN_SORT = 1'b0,
    OWN_HOST = 1'b1
  } aer_owner_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic CLK,
  input  logic RSTN,
  input  logic D,
  output logic Q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= D;
      r_q    <= r_meta;
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/aer_in_arbiter.sv
// Arbitrates sorter and host events onto a 4-phase AER input link,
// with round-robin tie-breaking, ACK timeouts, event counting and error flags.
module aer_in_arbiter
  import snn_aer_pkg::*;
#(
  parameter int unsigned ADDR_W      = AER_ADDR_W,
  parameter int unsigned ACK_TIMEOUT = AER_ACK_TIMEOUT
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 SORT_VALID,
  input  logic [ADDR_W-1:0]    SORT_ADDR,
  output logic                 SORT_BUSY,
  input  logic                 HOST_VALID,
  input  logic [ADDR_W-1:0]    HOST_ADDR,
  output logic                 HOST_BUSY,
  output logic [ADDR_W-1:0]    AERIN_ADDR,
  output logic                 AERIN_REQ,
  input  logic                 AERIN_ACK,
  output logic                 OWNER,
  output logic [AER_CNT_W-1:0] EVT_CNT,
  input  logic                 CNT_CLR,
  output logic                 TIMEOUT_ERR,
  output logic                 DROP_ERR,
  input  logic                 ERR_CLR
);

  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

  aer_arb_state_t         r_state, w_state_nxt;
  logic [TMR_W-1:0]       r_timer, w_timer_nxt;
  logic                   r_req, w_req_nxt;
  logic [ADDR_W-1:0]      r_aer_addr, w_aer_addr_nxt;
  aer_owner_t             r_owner, w_owner_nxt;
  logic                   r_rr_host, w_rr_host_nxt;
  logic                   r_to, w_to_nxt;
  logic                   w_to_set;
  logic                   w_done;

  logic                   r_pend_s, r_pend_h;
  logic                   r_samp_s, r_samp_h;
  logic                   r_aok_s, r_aok_h;
  logic [ADDR_W-1:0]      r_addr_s, r_addr_h;
  logic [AER_CNT_W-1:0]   r_evt_cnt;
  logic                   r_to_err, r_drop_err;

  logic w_ack_s;
  logic w_rdy_s, w_rdy_h, w_grant_host, w_tmo;
  logic w_acc_s, w_acc_h, w_drop;
  logic w_done_s, w_done_h, w_count;

  sync2 u_sync2 (
    .CLK  (CLK),
    .RSTN (RSTN),
    .D    (AERIN_ACK),
    .Q    (w_ack_s)
  );

  assign w_rdy_s      = r_pend_s & r_aok_s;
  assign w_rdy_h      = r_pend_h & r_aok_h;
  assign w_grant_host = w_rdy_h & (~w_rdy_s | r_rr_host);
  assign w_tmo        = (r_timer == TMR_W'(ACK_TIMEOUT - 1));

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer + TMR_W'(1);
    w_req_nxt      = r_req;
    w_aer_addr_nxt = r_aer_addr;
    w_owner_nxt    = r_owner;
    w_rr_host_nxt  = r_rr_host;
    w_to_nxt       = r_to;
    w_to_set       = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rdy_s || w_rdy_h) begin
          w_state_nxt    = ST_LOAD;
          w_timer_nxt    = '0;
          w_to_nxt       = 1'b0;
          w_owner_nxt    = w_grant_host ? OWN_HOST : OWN_SORT;
          w_aer_addr_nxt = w_grant_host ? r_addr_h : r_addr_s;
          // Pointer only moves on contested grants, so the tie winner yields next tie
          if (w_rdy_s && w_rdy_h) w_rr_host_nxt = ~w_grant_host;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_REQ;
        w_timer_nxt = '0;
        w_req_nxt   = 1'b1;
      end
      ST_REQ: begin
        if (w_ack_s || w_tmo) begin
          w_state_nxt = ST_RELEASE;
          w_timer_nxt = '0;
          w_req_nxt   = 1'b0;
          if (!w_ack_s) begin
            w_to_nxt = 1'b1;
            w_to_set = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (!w_ack_s || w_tmo) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
          w_done      = 1'b1;
          if (w_ack_s) begin
            w_to_nxt = 1'b1;
            w_to_set = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_req      <= 1'b0;
      r_aer_addr <= '0;
      r_owner    <= OWN_SORT;
      r_rr_host  <= 1'b0;
      r_to       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_req      <= w_req_nxt;
      r_aer_addr <= w_aer_addr_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_host  <= w_rr_host_nxt;
      r_to       <= w_to_nxt;
    end
  end

  assign w_acc_s  = SORT_VALID & ~r_pend_s;
  assign w_acc_h  = HOST_VALID & ~r_pend_h;
  assign w_drop   = (SORT_VALID & r_pend_s) | (HOST_VALID & r_pend_h);
  assign w_done_s = w_done & (r_owner == OWN_SORT);
  assign w_done_h = w_done & (r_owner == OWN_HOST);
  assign w_count  = w_done & ~w_to_nxt;

  // Request capture: flag on VALID, address one cycle later
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_pend_s <= 1'b0;
      r_pend_h <= 1'b0;
      r_samp_s <= 1'b0;
      r_samp_h <= 1'b0;
      r_aok_s  <= 1'b0;
      r_aok_h  <= 1'b0;
      r_addr_s <= '0;
      r_addr_h <= '0;
    end else begin
      r_pend_s <= (r_pend_s & ~w_done_s) | w_acc_s;
      r_pend_h <= (r_pend_h & ~w_done_h) | w_acc_h;
      r_samp_s <= w_acc_s;
      r_samp_h <= w_acc_h;
      if (w_done_s) begin
        r_aok_s <= 1'b0;
      end else if (r_samp_s) begin
        r_aok_s  <= 1'b1;
        r_addr_s <= SORT_ADDR;
      end
      if (w_done_h) begin
        r_aok_h <= 1'b0;
      end else if (r_samp_h) begin
        r_aok_h  <= 1'b1;
        r_addr_h <= HOST_ADDR;
      end
    end
  end

  // Event counter and sticky error flags; clears take priority
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_evt_cnt  <= '0;
      r_to_err   <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      if (CNT_CLR) begin
        r_evt_cnt <= '0;
      end else if (w_count && (r_evt_cnt != '1)) begin
        r_evt_cnt <= r_evt_cnt + AER_CNT_W'(1);
      end
      if (ERR_CLR) begin
        r_to_err   <= 1'b0;
        r_drop_err <= 1'b0;
      end else begin
        r_to_err   <= r_to_err | w_to_set;
        r_drop_err <= r_drop_err | w_drop;
      end
    end
  end

  assign SORT_BUSY   = r_pend_s;
  assign HOST_BUSY   = r_pend_h;
  assign AERIN_ADDR  = r_aer_addr;
  assign AERIN_REQ   = r_req;
  assign OWNER       = r_owner;
  assign EVT_CNT     = r_evt_cnt;
  assign TIMEOUT_ERR = r_to_err;
  assign DROP_ERR    = r_drop_err;

endmodule

// File: tb/tb_aer_in_arbiter.sv
// Directed bench for aer_in_arbiter: vector table for arbitration order,
// hand sequences for timeout, drop, reset, saturation and clear priority.
module tb_aer_in_arbiter;

  localparam int RESP_LAT = 3;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        SORT_VALID, HOST_VALID;
  logic [9:0]  SORT_ADDR, HOST_ADDR;
  logic        SORT_BUSY, HOST_BUSY;
  logic [9:0]  AERIN_ADDR;
  logic        AERIN_REQ, AERIN_ACK;
  logic        OWNER;
  logic [15:0] EVT_CNT;
  logic        CNT_CLR, ERR_CLR;
  logic        TIMEOUT_ERR, DROP_ERR;

  aer_in_arbiter dut (
    .CLK(CLK), .RSTN(RSTN),
    .SORT_VALID(SORT_VALID), .SORT_ADDR(SORT_ADDR), .SORT_BUSY(SORT_BUSY),
    .HOST_VALID(HOST_VALID), .HOST_ADDR(HOST_ADDR), .HOST_BUSY(HOST_BUSY),
    .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK),
    .OWNER(OWNER), .EVT_CNT(EVT_CNT), .CNT_CLR(CNT_CLR),
    .TIMEOUT_ERR(TIMEOUT_ERR), .DROP_ERR(DROP_ERR), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       own;
    logic [9:0] addr;
  } evt_t;

  typedef struct {
    logic        sv;
    logic [9:0]  sa;
    logic        hv;
    logic [9:0]  ha;
    int          n;
    logic [9:0]  a0;
    logic        o0;
    logic [9:0]  a1;
    logic        o1;
    logic [15:0] cnt;
  } vec_t;

  evt_t evq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   resp_en  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder: mirrors REQ onto ACK after RESP_LAT cycles
  initial begin
    int lat;
    AERIN_ACK = 1'b0;
    lat = 0;
    forever begin
      @(negedge CLK);
      if (!resp_en) begin
        AERIN_ACK = 1'b0;
        lat = 0;
      end else if (AERIN_REQ != AERIN_ACK) begin
        if (lat == RESP_LAT - 1) begin
          AERIN_ACK = AERIN_REQ;
          lat = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Record address/owner at each REQ rise
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge CLK);
      if (AERIN_REQ && !prev_req) evq.push_back({OWNER, AERIN_ADDR});
      prev_req = AERIN_REQ;
    end
  end

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (!SORT_BUSY && !HOST_BUSY && !AERIN_REQ) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic pulse(input logic sv, input logic [9:0] sa, input logic hv, input logic [9:0] ha);
    @(negedge CLK);
    SORT_VALID = sv;
    HOST_VALID = hv;
    if (sv) SORT_ADDR = sa;
    if (hv) HOST_ADDR = ha;
    @(negedge CLK);
    SORT_VALID = 1'b0;
    HOST_VALID = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int  req_cycles;
    bit  seen, ok;

    vecs[0] = '{1'b1, 10'h0FF, 1'b0, 10'h000, 1, 10'h0FF, 1'b0, 10'h000, 1'b0, 16'd1};
    vecs[1] = '{1'b1, 10'h005, 1'b1, 10'h009, 2, 10'h005, 1'b0, 10'h009, 1'b1, 16'd3};
    vecs[2] = '{1'b1, 10'h005, 1'b1, 10'h009, 2, 10'h009, 1'b1, 10'h005, 1'b0, 16'd5};
    vecs[3] = '{1'b1, 10'h005, 1'b1, 10'h009, 2, 10'h005, 1'b0, 10'h009, 1'b1, 16'd7};
    vecs[4] = '{1'b0, 10'h000, 1'b1, 10'h3FF, 1, 10'h3FF, 1'b1, 10'h000, 1'b0, 16'd8};
    vecs[5] = '{1'b1, 10'h000, 1'b0, 10'h000, 1, 10'h000, 1'b0, 10'h000, 1'b0, 16'd9};

    RSTN = 1'b0; SORT_VALID = 1'b0; HOST_VALID = 1'b0;
    SORT_ADDR = '0; HOST_ADDR = '0; CNT_CLR = 1'b0; ERR_CLR = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_req", 32'(AERIN_REQ), 0);
    check("rst_addr", 32'(AERIN_ADDR), 0);
    check("rst_owner", 32'(OWNER), 0);
    check("rst_sort_busy", 32'(SORT_BUSY), 0);
    check("rst_host_busy", 32'(HOST_BUSY), 0);
    check("rst_cnt", 32'(EVT_CNT), 0);
    check("rst_to_err", 32'(TIMEOUT_ERR), 0);
    check("rst_drop_err", 32'(DROP_ERR), 0);
    RSTN = 1'b1;

    // Arbitration vector table
    for (int v = 0; v < 6; v++) begin
      evq.delete();
      pulse(vecs[v].sv, vecs[v].sa, vecs[v].hv, vecs[v].ha);
      wait_idle($sformatf("vec%0d_idle", v));
      check($sformatf("vec%0d_nevt", v), 32'(evq.size()), 32'(vecs[v].n));
      if (evq.size() >= 1) begin
        check($sformatf("vec%0d_addr0", v), 32'(evq[0].addr), 32'(vecs[v].a0));
        check($sformatf("vec%0d_own0", v), 32'(evq[0].own), 32'(vecs[v].o0));
      end
      if (vecs[v].n == 2 && evq.size() >= 2) begin
        check($sformatf("vec%0d_addr1", v), 32'(evq[1].addr), 32'(vecs[v].a1));
        check($sformatf("vec%0d_own1", v), 32'(evq[1].own), 32'(vecs[v].o1));
      end
      check($sformatf("vec%0d_cnt", v), 32'(EVT_CNT), 32'(vecs[v].cnt));
      check($sformatf("vec%0d_drop", v), 32'(DROP_ERR), 0);
    end

    // ACK never arrives: REQ held ACK_TIMEOUT cycles, event not counted
    resp_en = 1'b0;
    pulse(1'b1, 10'h012, 1'b0, 10'h000);
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (AERIN_REQ) begin
        req_cycles = 1;
        break;
      end
    end
    for (int i = 0; i < 200 && req_cycles > 0; i++) begin
      @(negedge CLK);
      if (AERIN_REQ) req_cycles++;
      else break;
    end
    check("to_req_cycles", 32'(req_cycles), 32'd64);
    wait_idle("to_idle");
    check("to_err", 32'(TIMEOUT_ERR), 1);
    check("to_cnt", 32'(EVT_CNT), 32'd9);
    @(negedge CLK); ERR_CLR = 1'b1;
    @(negedge CLK); ERR_CLR = 1'b0;
    check("to_err_clr", 32'(TIMEOUT_ERR), 0);
    resp_en = 1'b1;

    // Second VALID while busy is dropped
    evq.delete();
    pulse(1'b1, 10'h021, 1'b0, 10'h000);
    @(negedge CLK);
    pulse(1'b1, 10'h022, 1'b0, 10'h000);
    wait_idle("drop_idle");
    check("drop_err", 32'(DROP_ERR), 1);
    check("drop_nevt", 32'(evq.size()), 1);
    if (evq.size() >= 1) check("drop_addr", 32'(evq[0].addr), 32'h021);
    check("drop_cnt", 32'(EVT_CNT), 32'd10);

    // ERR_CLR beats a simultaneous drop
    evq.delete();
    pulse(1'b1, 10'h031, 1'b0, 10'h000);
    @(negedge CLK);
    SORT_VALID = 1'b1; ERR_CLR = 1'b1;
    @(negedge CLK);
    SORT_VALID = 1'b0; ERR_CLR = 1'b0;
    check("errclr_wins", 32'(DROP_ERR), 0);
    wait_idle("errclr_idle");
    check("errclr_cnt", 32'(EVT_CNT), 32'd11);

    // One-cycle reset during REQ
    resp_en = 1'b0;
    pulse(1'b1, 10'h055, 1'b1, 10'h066);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (AERIN_REQ) begin
        ok = 1'b1;
        break;
      end
    end
    check("mrst_req_seen", 32'(ok), 1);
    repeat (3) @(negedge CLK);
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    check("mrst_req", 32'(AERIN_REQ), 0);
    check("mrst_addr", 32'(AERIN_ADDR), 0);
    check("mrst_owner", 32'(OWNER), 0);
    check("mrst_busy", 32'({SORT_BUSY, HOST_BUSY}), 0);
    check("mrst_cnt", 32'(EVT_CNT), 0);
    check("mrst_errs", 32'({TIMEOUT_ERR, DROP_ERR}), 0);
    resp_en = 1'b1;
    repeat (2) @(negedge CLK);
    evq.delete();
    pulse(1'b1, 10'h1AB, 1'b0, 10'h000);
    wait_idle("mrst_post_idle");
    check("mrst_post_nevt", 32'(evq.size()), 1);
    if (evq.size() >= 1) check("mrst_post_addr", 32'(evq[0].addr), 32'h1AB);
    check("mrst_post_cnt", 32'(EVT_CNT), 1);
    check("mrst_post_errs", 32'({TIMEOUT_ERR, DROP_ERR}), 0);

    // Saturation at 16'hFFFF
    @(negedge CLK);
    force dut.r_evt_cnt = 16'hFFFF;
    @(negedge CLK);
    release dut.r_evt_cnt;
    @(negedge CLK);
    check("sat_preload", 32'(EVT_CNT), 32'hFFFF);
    pulse(1'b1, 10'h0AA, 1'b0, 10'h000);
    wait_idle("sat_idle");
    check("sat_cnt", 32'(EVT_CNT), 32'hFFFF);

    // CNT_CLR on the exact increment cycle (two sync stages after ACK falls)
    pulse(1'b0, 10'h000, 1'b1, 10'h0BB);
    seen = 1'b0;
    ok   = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      #1;
      if (AERIN_ACK) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    check("clr_ack_fall", 32'(ok), 1);
    @(negedge CLK);
    @(negedge CLK);
    CNT_CLR = 1'b1;
    @(negedge CLK);
    CNT_CLR = 1'b0;
    check("clr_host_busy", 32'(HOST_BUSY), 0);
    check("clr_wins", 32'(EVT_CNT), 0);
    pulse(1'b0, 10'h000, 1'b1, 10'h0CC);
    wait_idle("clr_post_idle");
    check("clr_post_cnt", 32'(EVT_CNT), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
